// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM encodings, parity modes,
//                bit-period divisor and parity helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clocks per bit; callers guarantee an exact integer ratio of at least 2.
    function automatic int calc_div(input int clkFreq, input int baudRate);
        return clkFreq / baudRate;
    endfunction

    // Data must already be masked to the frame's data width.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic result;
        result = 1'b0;
        if (mode == PARITY_ODD)
            result = ~^data;
        else if (mode == PARITY_EVEN)
            result = ^data;
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period counter 0..DIV-1 with synchronous clear and a
//                BitEnd strobe on the last count of each period.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Clear,
    output logic BitEnd
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] c_cntMax = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_count <= '0;
        else if (Clear || (r_count == c_cntMax))
            r_count <= '0;
        else
            r_count <= r_count + 1'b1;
    end

    assign BitEnd = (r_count == c_cntMax);

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_engine
//  Description : UART transmitter; serialises one accepted byte LSB-first
//                as start / data / optional parity / stop bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] TxData,
    input  logic       TxStart,
    output logic       TxReady,
    output logic       TxBusy,
    output logic       TxDone,
    output logic       Tx
);

    localparam int         DIV            = calc_div(CLK_FREQ, BAUD_RATE);
    localparam logic [7:0] c_dataMask     = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0] c_lastDataIdx  = 3'(DATA_BITS - 1);
    localparam logic [2:0] c_lastStopIdx  = 3'(STOP_BITS - 1);

    uart_state_e r_state, w_nextState;
    logic [7:0]  r_shift, w_nextShift;
    logic [2:0]  r_bitIdx, w_nextBitIdx;
    logic        r_parity, w_nextParity;
    logic        r_tx, w_nextTx;
    logic        r_txDone, w_nextTxDone;
    logic        r_txReady;
    logic        w_bitEnd;
    logic        w_baudClear;
    logic [7:0]  w_maskedData;

    assign w_maskedData = TxData & c_dataMask;

    // Counter restarts at every state change and is held at zero while idle.
    assign w_baudClear = (r_state == ST_IDLE) || (w_nextState != r_state);

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Clear  (w_baudClear),
        .BitEnd (w_bitEnd)
    );

    always_comb begin
        w_nextState  = r_state;
        w_nextShift  = r_shift;
        w_nextBitIdx = r_bitIdx;
        w_nextParity = r_parity;
        w_nextTx     = r_tx;
        w_nextTxDone = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_nextTx = 1'b1;
                if (TxStart) begin
                    w_nextState  = ST_START;
                    w_nextShift  = w_maskedData;
                    w_nextParity = parity_bit(w_maskedData, PARITY);
                    w_nextBitIdx = 3'd0;
                    w_nextTx     = 1'b0;
                end
            end
            ST_START: begin
                if (w_bitEnd) begin
                    w_nextState = ST_DATA;
                    w_nextTx    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bitEnd) begin
                    if (r_bitIdx == c_lastDataIdx) begin
                        w_nextBitIdx = 3'd0;
                        if (PARITY != PARITY_NONE) begin
                            w_nextState = ST_PARITY;
                            w_nextTx    = r_parity;
                        end else begin
                            w_nextState = ST_STOP;
                            w_nextTx    = 1'b1;
                        end
                    end else begin
                        // Shift register's bit 0 is always the bit on the line.
                        w_nextBitIdx = r_bitIdx + 3'd1;
                        w_nextShift  = r_shift >> 1;
                        w_nextTx     = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bitEnd) begin
                    w_nextState  = ST_STOP;
                    w_nextBitIdx = 3'd0;
                    w_nextTx     = 1'b1;
                end
            end
            ST_STOP: begin
                w_nextTx = 1'b1;
                if (w_bitEnd) begin
                    if (r_bitIdx == c_lastStopIdx) begin
                        w_nextState  = ST_IDLE;
                        w_nextBitIdx = 3'd0;
                        w_nextTxDone = 1'b1;
                    end else begin
                        w_nextBitIdx = r_bitIdx + 3'd1;
                    end
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextTx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= 8'd0;
            r_bitIdx  <= 3'd0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_txDone  <= 1'b0;
            r_txReady <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_shift   <= w_nextShift;
            r_bitIdx  <= w_nextBitIdx;
            r_parity  <= w_nextParity;
            r_tx      <= w_nextTx;
            r_txDone  <= w_nextTxDone;
            r_txReady <= (w_nextState == ST_IDLE);
        end
    end

    assign Tx      = r_tx;
    assign TxDone  = r_txDone;
    assign TxReady = r_txReady;
    assign TxBusy  = ~r_txReady;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_engine
//  Description : Self-checking bench for uart_tx_engine in four frame formats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

    localparam int DIV = 10;
    // Per unit: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 7N2
    localparam int P_DB  [4] = '{8, 8, 8, 7};
    localparam int P_PAR [4] = '{0, 2, 1, 0};
    localparam int P_STOP[4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] txStart = 4'b0;
    logic [7:0] txData [4];
    wire  [3:0] txReady, txBusy, txDone, txLine;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut0 (.Clk(clk), .Rst_n(rst_n), .TxData(txData[0]), .TxStart(txStart[0]),
              .TxReady(txReady[0]), .TxBusy(txBusy[0]), .TxDone(txDone[0]), .Tx(txLine[0]));
    uart_tx_engine #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        dut1 (.Clk(clk), .Rst_n(rst_n), .TxData(txData[1]), .TxStart(txStart[1]),
              .TxReady(txReady[1]), .TxBusy(txBusy[1]), .TxDone(txDone[1]), .Tx(txLine[1]));
    uart_tx_engine #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        dut2 (.Clk(clk), .Rst_n(rst_n), .TxData(txData[2]), .TxStart(txStart[2]),
              .TxReady(txReady[2]), .TxBusy(txBusy[2]), .TxDone(txDone[2]), .Tx(txLine[2]));
    uart_tx_engine #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
        dut3 (.Clk(clk), .Rst_n(rst_n), .TxData(txData[3]), .TxStart(txStart[3]),
              .TxReady(txReady[3]), .TxBusy(txBusy[3]), .TxDone(txDone[3]), .Tx(txLine[3]));

    task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s unit%0d: observed %0h expected %0h", tag, u, obs, exp);
        end
    endtask

    // Reference frame: line level for each bit period, built from the format rules.
    task automatic buildFrame(input int u, input logic [7:0] data, output bit bits[$]);
        int ones;
        bits = {};
        bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < P_DB[u]; i++) begin
            bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (P_PAR[u] == 2) bits.push_back(bit'(ones % 2));
        if (P_PAR[u] == 1) bits.push_back(bit'((ones % 2) == 0));
        for (int s = 0; s < P_STOP[u]; s++) bits.push_back(1'b1);
    endtask

    // chained: TxStart already held high from the previous frame's TxDone cycle.
    // holdStart: keep TxStart high through the frame and present nextData in the TxDone cycle.
    // disturb: pulse TxStart and alter TxData mid-frame.
    task automatic sendFrame(input int u, input logic [7:0] data, input bit chained,
                             input bit holdStart, input logic [7:0] nextData, input bit disturb);
        bit bits[$];
        int frameLen;
        buildFrame(u, data, bits);
        frameLen = bits.size() * DIV;
        if (!chained) begin
            @(negedge clk);
            txStart[u] = 1'b1;
            txData[u]  = data;
        end
        chk("ready_before", u, 32'(txReady[u]), 32'd1);
        @(posedge clk);
        for (int n = 1; n <= frameLen + 1; n++) begin
            @(negedge clk);
            if (n == 1 && !holdStart) txStart[u] = 1'b0;
            if (disturb && n == 25) begin txStart[u] = 1'b1; txData[u] = ~data; end
            if (disturb && n == 26) txStart[u] = 1'b0;
            if (disturb && n == 40) txData[u] = 8'($urandom);
            if (n <= frameLen) begin
                chk("tx_bit", u, 32'(txLine[u]), 32'(bits[(n - 1) / DIV]));
                chk("done_low", u, 32'(txDone[u]), 32'd0);
                chk("ready_low", u, 32'(txReady[u]), 32'd0);
                chk("busy_high", u, 32'(txBusy[u]), 32'd1);
            end else begin
                chk("done_pulse", u, 32'(txDone[u]), 32'd1);
                chk("ready_at_done", u, 32'(txReady[u]), 32'd1);
                chk("tx_idle_at_done", u, 32'(txLine[u]), 32'd1);
                if (holdStart) txData[u] = nextData;
            end
        end
    endtask

    task automatic idleCheck(input int u, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            chk("idle_tx", u, 32'(txLine[u]), 32'd1);
            chk("idle_done", u, 32'(txDone[u]), 32'd0);
            chk("idle_ready", u, 32'(txReady[u]), 32'd1);
        end
    endtask

    initial begin
        bit bits[$];
        for (int u = 0; u < 4; u++) txData[u] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            chk("rst_tx", u, 32'(txLine[u]), 32'd1);
            chk("rst_ready", u, 32'(txReady[u]), 32'd1);
            chk("rst_busy", u, 32'(txBusy[u]), 32'd0);
            chk("rst_done", u, 32'(txDone[u]), 32'd0);
        end
        rst_n = 1'b1;
        idleCheck(0, 2);

        // 8N1 and parity variants with 0xA5
        sendFrame(0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
        sendFrame(1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
        sendFrame(2, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);

        // Back-to-back with TxStart held high; second frame follows the TxDone cycle
        sendFrame(0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);
        sendFrame(0, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
        idleCheck(0, 3);

        // Mid-frame TxStart and TxData changes are ignored; exactly one TxDone
        sendFrame(0, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1);
        idleCheck(0, 15);

        // Asynchronous reset in the middle of the data bits
        buildFrame(0, 8'h55, bits);
        @(negedge clk);
        txStart[0] = 1'b1;
        txData[0]  = 8'h55;
        @(posedge clk);
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            txStart[0] = 1'b0;
            chk("pre_rst_bit", 0, 32'(txLine[0]), 32'(bits[(n - 1) / DIV]));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 0, 32'(txLine[0]), 32'd1);
        chk("async_rst_ready", 0, 32'(txReady[0]), 32'd1);
        chk("async_rst_busy", 0, 32'(txBusy[0]), 32'd0);
        chk("async_rst_done", 0, 32'(txDone[0]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_done", 0, 32'(txDone[0]), 32'd0);
        end
        rst_n = 1'b1;
        idleCheck(0, 12);
        sendFrame(0, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0);

        // 7 data bits, 2 stop bits: bit 7 must never reach the line
        sendFrame(3, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
        sendFrame(3, 8'h7F, 1'b0, 1'b0, 8'h00, 1'b0);
        sendFrame(3, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0);

        // Random bytes in every format
        for (int r = 0; r < 3; r++) begin
            for (int u = 0; u < 4; u++) begin
                sendFrame(u, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 8'h00, 1'b0);
            end
        end
        idleCheck(3, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
